pipe_hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage MIPS core.
- Produces the `stall`/`Flush` controls for the IF/ID register, the bubble control for ID/EXE, and a global freeze during multi-cycle data-memory accesses.
- Sits beside the datapath. Takes register-address and control bits from the ID, EXE and MEM stages; drives the hold/clear inputs of every stage register.
- Contains the memory-wait FSM and its latency counter.

---
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/freeze control for the 5-stage MIPS pipeline: load-use stall, branch flush, memory-wait freeze.
// Optional HAZARD_PERF_EN adds saturating performance counters for freeze, load-use and flush cycles.
module pipe_hazard_ctrl #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_two_src,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_read,
  input  logic       branch_taken,
  input  logic       mem_req,
  output logic       if_stall,
  output logic       if_flush,
  output logic       id_bubble,
  output logic       freeze,
  output logic       mem_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_freeze_cyc,
  output logic [31:0] perf_lu_stall,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             load_use;
  logic             lu_stall;

  assign load_use = exe_mem_read && exe_wb_en && (exe_dest != 5'd0) &&
                    ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if_stall   = 1'b0;
    if_flush   = 1'b0;
    id_bubble  = 1'b0;
    freeze     = 1'b0;
    mem_done   = 1'b0;
    lu_stall   = 1'b0;
    // DONE ignores mem_req: the finished instruction is still sitting in MEM
    if ((state == IDLE && mem_req) || state == WAIT) begin
      freeze   = 1'b1;
      if_stall = 1'b1;
    end else if (branch_taken) begin
      if_flush  = 1'b1;
      id_bubble = 1'b1;
    end else if (load_use) begin
      if_stall  = 1'b1;
      id_bubble = 1'b1;
      lu_stall  = 1'b1;
    end
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (MEM_LAT == 1) begin
            state_next = DONE;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(MEM_LAT - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_next = DONE;
        else           cnt_next   = cnt - 1'b1;
      end
      DONE: begin
        mem_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_freeze_cyc <= '0;
      perf_lu_stall   <= '0;
      perf_flush      <= '0;
    end else begin
      if (freeze && perf_freeze_cyc != 32'hFFFF_FFFF) perf_freeze_cyc <= perf_freeze_cyc + 1'b1;
      if (lu_stall && perf_lu_stall != 32'hFFFF_FFFF) perf_lu_stall <= perf_lu_stall + 1'b1;
      if (if_flush && perf_flush != 32'hFFFF_FFFF)    perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized run against a remaining-cycles model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_src1, id_src2, exe_dest;
  logic       id_two_src, exe_wb_en, exe_mem_read, branch_taken, mem_req;
  logic       if_stall_a, if_flush_a, id_bubble_a, freeze_a, mem_done_a;
  logic       if_stall_b, if_flush_b, id_bubble_b, freeze_b, mem_done_b;
`ifdef HAZARD_PERF_EN
  logic [31:0] pf_a, pl_a, pfl_a, pf_b, pl_b, pfl_b;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Model state: cycles of freeze still owed, and whether the done cycle is next
  int frz_left[2];
  bit done_pend[2];
  int lat_of[2] = '{4, 2};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_LAT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .branch_taken(branch_taken), .mem_req(mem_req), .if_stall(if_stall_a), .if_flush(if_flush_a),
    .id_bubble(id_bubble_a), .freeze(freeze_a), .mem_done(mem_done_a)
`ifdef HAZARD_PERF_EN
    , .perf_freeze_cyc(pf_a), .perf_lu_stall(pl_a), .perf_flush(pfl_a)
`endif
  );

  pipe_hazard_ctrl #(.MEM_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .branch_taken(branch_taken), .mem_req(mem_req), .if_stall(if_stall_b), .if_flush(if_flush_b),
    .id_bubble(id_bubble_b), .freeze(freeze_b), .mem_done(mem_done_b)
`ifdef HAZARD_PERF_EN
    , .perf_freeze_cyc(pf_b), .perf_lu_stall(pl_b), .perf_flush(pfl_b)
`endif
  );

  // Output vectors are {if_stall, if_flush, id_bubble, freeze, mem_done}
  function automatic logic [4:0] obs_a();
    return {if_stall_a, if_flush_a, id_bubble_a, freeze_a, mem_done_a};
  endfunction

  function automatic logic [4:0] obs_b();
    return {if_stall_b, if_flush_b, id_bubble_b, freeze_b, mem_done_b};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      frz_left[k]  = 0;
      done_pend[k] = 1'b0;
    end
  endfunction

  // Expected outputs for the current cycle, then advance the model past the coming edge
  function automatic logic [4:0] model_cycle(int k);
    logic       lu;
    logic [4:0] haz, r;
    lu  = exe_mem_read && exe_wb_en && exe_dest != 0 &&
          (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
    haz = branch_taken ? 5'b01100 : (lu ? 5'b10100 : 5'b00000);
    if (done_pend[k]) begin
      r = haz | 5'b00001;
      done_pend[k] = 1'b0;
    end else if (frz_left[k] > 0) begin
      r = 5'b10010;
      frz_left[k]--;
      if (frz_left[k] == 0) done_pend[k] = 1'b1;
    end else if (mem_req) begin
      r = 5'b10010;
      frz_left[k] = lat_of[k] - 1;
      if (frz_left[k] == 0) done_pend[k] = 1'b1;
    end else begin
      r = haz;
    end
    return r;
  endfunction

  task automatic clear_inputs();
    id_src1 = 0; id_src2 = 0; id_two_src = 0; exe_dest = 0;
    exe_wb_en = 0; exe_mem_read = 0; branch_taken = 0; mem_req = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] o;
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #2;
    o = obs_a();
    n_cmp++;
    if (o !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b expected %b", o, 5'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    o = obs_a();
    n_cmp++;
    if (o !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_first_cycle: got %b expected %b", o, 5'b0);
    end
  endtask

  task automatic test_mem_freeze();
    logic [4:0] exp_seq[6] = '{5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b00001, 5'b00000};
    logic [4:0] o;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_req = (i < 5);
      #1;
      o = obs_a();
      n_cmp++;
      if (o !== exp_seq[i]) begin
        n_fail++;
        $display("[TB] FAIL mem_freeze cyc%0d: got %b expected %b", i + 1, o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [4:0] o;
    logic [4:0] exp_v[3] = '{5'b10100, 5'b00000, 5'b00000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      exe_mem_read = 1; exe_wb_en = 1;
      case (i)
        0: begin exe_dest = 5; id_src1 = 5; id_src2 = 7; id_two_src = 1; end
        1: begin exe_dest = 0; id_src1 = 0; id_src2 = 0; id_two_src = 1; end
        default: begin exe_dest = 5; id_src1 = 3; id_src2 = 5; id_two_src = 0; end
      endcase
      #1;
      o = obs_a();
      n_cmp++;
      if (o !== exp_v[i]) begin
        n_fail++;
        $display("[TB] FAIL load_use pat%0d: got %b expected %b", i, o, exp_v[i]);
      end
    end
    @(negedge clk);
    clear_inputs();
    id_src1 = 5; exe_dest = 5; exe_wb_en = 1;
    #1;
    o = obs_a();
    n_cmp++;
    if (o !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL load_use_not_load: got %b expected %b", o, 5'b0);
    end
  endtask

  task automatic test_branch_priority();
    logic [4:0] o;
    @(negedge clk);
    clear_inputs();
    exe_mem_read = 1; exe_wb_en = 1; exe_dest = 9; id_src1 = 9; branch_taken = 1;
    #1;
    o = obs_a();
    n_cmp++;
    if (o !== 5'b01100) begin
      n_fail++;
      $display("[TB] FAIL branch_priority: got %b expected %b", o, 5'b01100);
    end
  endtask

  task automatic test_branch_during_wait();
    logic [4:0] exp_seq[6] = '{5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b01101, 5'b01100};
    logic [4:0] o;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      branch_taken = 1;
      mem_req = (i < 5);
      #1;
      o = obs_a();
      n_cmp++;
      if (o !== exp_seq[i]) begin
        n_fail++;
        $display("[TB] FAIL branch_wait cyc%0d: got %b expected %b", i + 1, o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [4:0] exp_seq[5] = '{5'b10010, 5'b10010, 5'b10010, 5'b10010, 5'b00001};
    logic [4:0] o;
    do_reset();
    @(negedge clk);
    mem_req = 1;
    @(negedge clk);
    @(negedge clk);
    mem_req = 0;
    #1;
    rst = 1'b0;
    #1;
    o = obs_a();
    n_cmp++;
    if (o !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_wait: got %b expected %b", o, 5'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      o = obs_a();
      n_cmp++;
      if (o !== 5'b0) begin
        n_fail++;
        $display("[TB] FAIL after_reset_idle cyc%0d: got %b expected %b", i, o, 5'b0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_req = 1;
      #1;
      o = obs_a();
      n_cmp++;
      if (o !== exp_seq[i]) begin
        n_fail++;
        $display("[TB] FAIL refreeze cyc%0d: got %b expected %b", i + 1, o, exp_seq[i]);
      end
    end
    @(negedge clk);
    mem_req = 0;
  endtask

  task automatic test_back_to_back();
    logic       exp_frz[6]  = '{1, 1, 0, 1, 1, 0};
    logic       exp_done[6] = '{0, 0, 1, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_req = 1;
      #1;
      n_cmp++;
      if (freeze_b !== exp_frz[i] || mem_done_b !== exp_done[i]) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cyc%0d: freeze/done got %b%b expected %b%b",
                 i + 1, freeze_b, mem_done_b, exp_frz[i], exp_done[i]);
      end
    end
    @(negedge clk);
    mem_req = 0;
`ifdef HAZARD_PERF_EN
    #1;
    n_cmp++;
    if (pf_b !== 32'd4) begin
      n_fail++;
      $display("[TB] FAIL perf_freeze_cyc: got %0d expected %0d", pf_b, 4);
    end
`endif
  endtask

  task automatic test_random();
    logic [4:0] oa, ob, ea, eb;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      mem_req      = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      exe_mem_read = $urandom_range(0, 1);
      exe_wb_en    = ($urandom_range(0, 3) != 0);
      exe_dest     = 5'($urandom_range(0, 3));
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      id_two_src   = $urandom_range(0, 1);
      #1;
      ea = model_cycle(0);
      eb = model_cycle(1);
      oa = obs_a();
      ob = obs_b();
      n_cmp++;
      if (oa !== ea) begin
        n_fail++;
        $display("[TB] FAIL random_lat4 step%0d: got %b expected %b", n, oa, ea);
      end
      n_cmp++;
      if (ob !== eb) begin
        n_fail++;
        $display("[TB] FAIL random_lat2 step%0d: got %b expected %b", n, ob, eb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mem_freeze();
    test_load_use();
    test_branch_priority();
    test_branch_during_wait();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
